// File: rtl/v8502_arb_pkg.sv
// ----------------------------------------------------------------------------
// v8502_arb_pkg
// Shared types and constants for the V8502 DMA bus arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, STALL, GRANT, HANDBACK)
//   RDY_LEAD_DEFAULT : default number of STALL cycles between RDY and AEC falling
//   CNT_W            : width of the stall counter (covers RDY_LEAD up to 3)
//   onehot2()        : requester index -> one-hot grant vector
// ----------------------------------------------------------------------------
package v8502_arb_pkg;

    localparam int unsigned RDY_LEAD_DEFAULT = 3;
    localparam int unsigned CNT_W            = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        GRANT    = 2'd2,
        HANDBACK = 2'd3
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/v8502_rr_pick.sv
// ----------------------------------------------------------------------------
// v8502_rr_pick
// Combinational 2-way round-robin picker.
//   req_i    [1:0] : active-high requests, one bit per requester
//   last_i         : index of the requester granted most recently
//   winner_o       : index of the chosen requester (don't-care when !valid_o)
//   valid_o        : at least one request is present
// ----------------------------------------------------------------------------
module v8502_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    assign valid_o  = |req_i;
    // A lone request wins outright; on a tie the one not granted last wins.
    assign winner_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/v8502_bus_arbiter.sv
// ----------------------------------------------------------------------------
// v8502_bus_arbiter
// Arbitrates the 6502 bus between the CPU and two DMA requesters. A request
// first drops RDY to halt the CPU, waits RDY_LEAD cycles, then drops AEC to
// float the CPU address/R_W and grants the bus one-hot to the winner.
// All state changes on the falling edge of phi2.
//
// Ports:
//   phi2           : phase-2 system clock (falling edge active)
//   _reset         : asynchronous, active-low reset
//   req      [1:0] : DMA requests, active-high
//   r_w_6502       : CPU R/_W, high = read cycle
//   rdy            : CPU RDY, low halts the CPU on its next read
//   aec            : address enable, low floats CPU address and R/_W
//   gnt      [1:0] : one-hot grant, zero when no requester owns the bus
//   busy           : high in every state except IDLE
//
// Parameter RDY_LEAD (1..3): STALL cycles between RDY falling and AEC falling.
//
// Build option V8502_ARB_FAST_STALL_EN: when defined, a STALL cycle in which
// r_w_6502=1 is sampled proves the CPU is halted, so STALL exits to GRANT on
// the following edge. When undefined, STALL always lasts RDY_LEAD cycles.
// ----------------------------------------------------------------------------
module v8502_bus_arbiter
    import v8502_arb_pkg::*;
#(
    parameter int unsigned RDY_LEAD = RDY_LEAD_DEFAULT
) (
    input  logic       phi2,
    input  logic       _reset,
    input  logic [1:0] req,
    input  logic       r_w_6502,
    output logic       rdy,
    output logic       aec,
    output logic [1:0] gnt,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RDY_LEAD - 1);

    arb_state_e       state_q, state_d;
    logic             winner_q, winner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fast_q, fast_d;
    logic             rdy_d, aec_d, busy_d;
    logic [1:0]       gnt_d;

    logic             pick_winner;
    logic             pick_valid;
    logic             stall_fast;

`ifdef V8502_ARB_FAST_STALL_EN
    assign stall_fast = r_w_6502;
`else
    logic unused_r_w;
    assign stall_fast = 1'b0;
    assign unused_r_w = r_w_6502;
`endif

    v8502_rr_pick u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        fast_d   = fast_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = STALL;
                    winner_d = pick_winner;
                    cnt_d    = CNT_LOAD;
                    fast_d   = 1'b0;
                end
            end
            STALL: begin
                if (!req[winner_q]) begin
                    // Abort: no grant, pointer untouched; the other requester
                    // is seen again from IDLE on the next edge.
                    state_d = IDLE;
                    cnt_d   = '0;
                    fast_d  = 1'b0;
                end else if (cnt_q == '0 || fast_q) begin
                    state_d = GRANT;
                    last_d  = winner_q;
                    cnt_d   = '0;
                    fast_d  = 1'b0;
                end else begin
                    // Only reached with cnt_q != 0, so the counter never wraps.
                    cnt_d  = cnt_q - CNT_W'(1);
                    fast_d = stall_fast;
                end
            end
            GRANT: begin
                if (!req[winner_q]) begin
                    if (req[~winner_q]) begin
                        // CPU is still halted: hand the bus straight over.
                        winner_d = ~winner_q;
                        last_d   = ~winner_q;
                    end else begin
                        state_d = HANDBACK;
                    end
                end
            end
            HANDBACK: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    winner_d = pick_winner;
                    last_d   = pick_winner;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come out registered.
        rdy_d  = (state_d == IDLE);
        aec_d  = (state_d == IDLE) || (state_d == STALL);
        gnt_d  = (state_d == GRANT) ? onehot2(winner_d) : 2'b00;
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(negedge phi2 or negedge _reset) begin
        if (!_reset) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            fast_q   <= 1'b0;
            rdy      <= 1'b1;
            aec      <= 1'b1;
            gnt      <= 2'b00;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            fast_q   <= fast_d;
            rdy      <= rdy_d;
            aec      <= aec_d;
            gnt      <= gnt_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_v8502_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_v8502_bus_arbiter
// Self-checking bench for v8502_bus_arbiter (RDY_LEAD = 3). A bus-ownership
// model (who owns the bus, who is pending, whether the CPU is halted) predicts
// rdy/aec/gnt/busy every cycle; directed scenarios add literal expectations.
// Honours V8502_ARB_FAST_STALL_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_v8502_bus_arbiter;

    localparam int LEAD = 3;

    logic       phi2  = 1'b1;
    logic       rst_n = 1'b1;
    logic [1:0] req   = 2'b00;
    logic       r_w   = 1'b0;
    logic       rdy, aec, busy;
    logic [1:0] gnt;

    int n_total = 0;
    int n_bad   = 0;

    v8502_bus_arbiter #(.RDY_LEAD(LEAD)) dut (
        .phi2     (phi2),
        ._reset   (rst_n),
        .req      (req),
        .r_w_6502 (r_w),
        .rdy      (rdy),
        .aec      (aec),
        .gnt      (gnt),
        .busy     (busy)
    );

    always #5 phi2 = ~phi2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus-ownership model ----------------
    int m_owner   = -1;   // requester holding the bus, -1 = none
    int m_pending = -1;   // requester waiting for the CPU to halt, -1 = none
    int m_last    = 1;    // requester granted most recently
    int m_left    = 0;    // halt cycles still owed before the bus is given
    bit m_halted  = 1'b0; // CPU held off the bus
    bit m_turn    = 1'b0; // one-cycle bus turnaround in progress
    bit m_fast    = 1'b0; // CPU seen reading while halted

    function automatic int rr(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        return r[1] ? 1 : 0;
    endfunction

    always @(negedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_pending = -1; m_last = 1; m_left = 0;
            m_halted = 1'b0; m_turn = 1'b0; m_fast = 1'b0;
        end else if (!m_halted) begin
            if (req != 2'b00) begin
                m_pending = rr(req, m_last);
                m_halted  = 1'b1;
                m_left    = LEAD;
                m_fast    = 1'b0;
            end
        end else if (m_pending >= 0) begin
            if (!req[m_pending]) begin
                m_pending = -1;
                m_halted  = 1'b0;
                m_fast    = 1'b0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0 || m_fast) begin
                    m_owner   = m_pending;
                    m_last    = m_pending;
                    m_pending = -1;
                    m_fast    = 1'b0;
                end else begin
`ifdef V8502_ARB_FAST_STALL_EN
                    m_fast = r_w;
`endif
                end
            end
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                if (req[1 - m_owner]) begin
                    m_owner = 1 - m_owner;
                    m_last  = m_owner;
                end else begin
                    m_owner = -1;
                    m_turn  = 1'b1;
                end
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
            if (req != 2'b00) begin
                m_owner = rr(req, m_last);
                m_last  = m_owner;
            end else begin
                m_halted = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [1:0] e_gnt;
        forever begin
            @(negedge phi2);
            #2;
            e_gnt = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
            check("m_rdy",  rdy,  !m_halted);
            check("m_aec",  aec,  !(m_owner >= 0 || m_turn));
            check("m_gnt",  gnt,  e_gnt);
            check("m_busy", busy, m_halted);
            check("inv_onehot", ($countones(gnt) <= 1), 1);
            check("inv_aec_rdy", (!aec && rdy), 0);
            check("inv_busy_idle", busy, !rdy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge phi2);
        #3;
    endtask

    task automatic expect_out(input string tag, input logic e_rdy, input logic e_aec,
                              input logic [1:0] e_gnt);
        check({tag, "_rdy"},  rdy,  e_rdy);
        check({tag, "_aec"},  aec,  e_aec);
        check({tag, "_gnt"},  gnt,  e_gnt);
        check({tag, "_busy"}, busy, !e_rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        r_w   = 1'b0;
        #1;
        expect_out("rst", 1'b1, 1'b1, 2'b00);
        tick();
        rst_n = 1'b1;
    endtask

    logic [2:0] tab [24] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b011,
                             3'b010, 3'b011, 3'b001, 3'b000, 3'b011, 3'b100,
                             3'b111, 3'b111, 3'b110, 3'b110, 3'b000, 3'b010,
                             3'b000, 3'b001, 3'b101, 3'b011, 3'b000, 3'b000};

    initial begin
        #1;
        do_reset();

        // Single request: stall 3 cycles, grant, burst, handback, idle.
        req = 2'b01;
        tick(); expect_out("s1_stall0", 1'b0, 1'b1, 2'b00);
        tick(); tick(); expect_out("s1_stall2", 1'b0, 1'b1, 2'b00);
        tick(); expect_out("s1_grant", 1'b0, 1'b0, 2'b01);
        repeat (5) tick();
        expect_out("s1_burst", 1'b0, 1'b0, 2'b01);
        req = 2'b00;
        tick(); expect_out("s1_handback", 1'b0, 1'b0, 2'b00);
        tick(); expect_out("s1_idle", 1'b1, 1'b1, 2'b00);

        // Tie after reset: requester 0 first, then direct switch to 1.
        do_reset();
        req = 2'b11;
        repeat (4) tick();
        expect_out("s2_tie", 1'b0, 1'b0, 2'b01);
        req = 2'b10;
        tick(); expect_out("s2_switch", 1'b0, 1'b0, 2'b10);
        req = 2'b00;
        tick(); expect_out("s2_handback", 1'b0, 1'b0, 2'b00);
        tick(); expect_out("s2_idle", 1'b1, 1'b1, 2'b00);

        // Abort in STALL leaves the pointer alone: next tie grants 01.
        do_reset();
        req = 2'b10;
        tick(); expect_out("s3_stall", 1'b0, 1'b1, 2'b00);
        req = 2'b00;
        tick(); expect_out("s3_abort", 1'b1, 1'b1, 2'b00);
        req = 2'b11;
        repeat (4) tick();
        expect_out("s3_tie", 1'b0, 1'b0, 2'b01);
        req = 2'b00;
        tick(); tick();

        // Abort with the other requester waiting: re-evaluated from IDLE.
        req = 2'b01;
        tick();
        req = 2'b10;
        tick(); expect_out("s4_abort", 1'b1, 1'b1, 2'b00);
        tick(); expect_out("s4_restall", 1'b0, 1'b1, 2'b00);
        repeat (3) tick();
        expect_out("s4_grant", 1'b0, 1'b0, 2'b10);
        // HANDBACK straight into GRANT with no stall.
        req = 2'b00;
        tick(); expect_out("s4_handback", 1'b0, 1'b0, 2'b00);
        req = 2'b01;
        tick(); expect_out("s4_regrant", 1'b0, 1'b0, 2'b01);
        req = 2'b00;
        tick(); tick();

        // Read cycle seen in the first STALL cycle.
        req = 2'b01;
        tick();
        r_w = 1'b1;
        tick();
        r_w = 1'b0;
        tick();
`ifdef V8502_ARB_FAST_STALL_EN
        expect_out("s5_edge2", 1'b0, 1'b0, 2'b01);
`else
        expect_out("s5_edge2", 1'b0, 1'b1, 2'b00);
`endif
        tick(); expect_out("s5_edge3", 1'b0, 1'b0, 2'b01);
        req = 2'b00;
        tick(); tick();

        // Reset in the middle of a grant to requester 1.
        do_reset();
        req = 2'b10;
        repeat (4) tick();
        expect_out("s6_grant", 1'b0, 1'b0, 2'b10);
        rst_n = 1'b0;
        #1;
        expect_out("s6_rst", 1'b1, 1'b1, 2'b00);
        tick();
        rst_n = 1'b1;
        req   = 2'b11;
        repeat (4) tick();
        expect_out("s6_tie", 1'b0, 1'b0, 2'b01);

        // Table of mixed request / R_W patterns, checked by the model.
        for (int i = 0; i < 24; i++) begin
            {r_w, req} = tab[i];
            tick();
        end
        req = 2'b00;
        r_w = 1'b0;
        repeat (3) tick();
        expect_out("end_idle", 1'b1, 1'b1, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
